// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared defaults, FSM state encoding and port-id type for the
//               two-port data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_ADDR_W = 6;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_t;

    typedef logic port_id_t;

    localparam port_id_t C_PORT0 = 1'b0;
    localparam port_id_t C_PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_pick
// Description : Combinational round-robin winner selection for two requesters.
//               On a tie the port that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // Winner selection: single requester wins outright, tie goes to the other port
    always_comb begin
        valid  = req0 | req1;
        winner = C_PORT0;
        if (req0 && req1) begin
            winner = (last_grant == C_PORT0) ? C_PORT1 : C_PORT0;
        end else if (req1) begin
            winner = C_PORT1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter in front of a single-port data
//               memory. One access per ACCESS cycle, response in RESP, and
//               arbitration in RESP allows back-to-back accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    dmem_state_t       state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              lat_port_q, lat_port_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              pick_valid;
    logic              pick_winner;

    dmem_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // State and datapath registers; reset clears everything so strobes drop at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= C_PORT1;
            lat_port_q   <= C_PORT0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_port_q   <= lat_port_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Next-state, request latching, read-data capture and output decode
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_port_d   = lat_port_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rvalid0  = 1'b0;
        rvalid1  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        busy     = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE, ST_RESP: begin
                // Latched fields from the previous access stay valid through RESP,
                // so the response pulse decodes from them while a new winner is picked
                if (state_q == ST_RESP && !lat_we_q) begin
                    rvalid0 = (lat_port_q == C_PORT0);
                    rvalid1 = (lat_port_q == C_PORT1);
                end
                if (pick_valid) begin
                    state_d      = ST_ACCESS;
                    last_grant_d = pick_winner;
                    lat_port_d   = pick_winner;
                    lat_we_d     = (pick_winner == C_PORT1) ? we1    : we0;
                    lat_addr_d   = (pick_winner == C_PORT1) ? addr1  : addr0;
                    lat_wdata_d  = (pick_winner == C_PORT1) ? wdata1 : wdata0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Requests are not looked at here; ACCESS is always a single cycle
                state_d  = ST_RESP;
                gnt0     = (lat_port_q == C_PORT0);
                gnt1     = (lat_port_q == C_PORT1);
                MemRead  = !lat_we_q;
                MemWrite = lat_we_q;
                if (!lat_we_q) begin
                    if (lat_port_q == C_PORT0) begin
                        rdata0_d = MemRData;
                    end else begin
                        rdata1_d = MemRData;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign MemAddr  = lat_addr_q;
    assign MemWData = lat_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter. Drivers push expected
//               grants and read responses; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [5:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        busy, MemRead, MemWrite;
    logic [5:0]  MemAddr;
    logic [31:0] MemWData, MemRData;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_gnt_cyc = -1;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } rd_exp_t;

    gnt_exp_t gq[$];
    rd_exp_t  rq[$];
    gnt_exp_t ge;
    rd_exp_t  re;

    dmem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .busy     (busy),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRData (MemRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: fixed preload pattern, overridden by committed writes
    logic [31:0] mem [0:63];
    logic        wr_flag [0:63];

    function automatic logic [31:0] mem_init(input logic [5:0] a);
        case (a)
            6'd2:    return 32'h0000_00A5;
            6'd5:    return 32'h0000_0055;
            default: return 32'hD000_0000 | {26'd0, a};
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [5:0] a);
        return (wr_flag[a] === 1'b1) ? mem[a] : mem_init(a);
    endfunction

    always @(posedge clk) begin
        if (MemWrite) begin
            mem[MemAddr]     <= MemWData;
            wr_flag[MemAddr] <= 1'b1;
        end
    end

    assign MemRData = MemRead ? mem_rd(MemAddr) : 32'd0;

    // Monitor: compare every grant and every read response against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 || gnt1) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL gnt_unexpected: got gnt0=%0b gnt1=%0b, required no grant", gnt0, gnt1);
                end else begin
                    ge = gq.pop_front();
                    if ((gnt0 && gnt1) || (gnt1 != ge.port) || (MemRead != !ge.we) ||
                        (MemWrite != ge.we) || (MemAddr != ge.addr) ||
                        (ge.we && (MemWData != ge.wdata))) begin
                        errors++;
                        $display("FAIL gnt_check: got gnt0=%0b gnt1=%0b rd=%0b wr=%0b addr=%0d wdata=%h, required port=%0d we=%0b addr=%0d wdata=%h",
                                 gnt0, gnt1, MemRead, MemWrite, MemAddr, MemWData,
                                 ge.port, ge.we, ge.addr, ge.wdata);
                    end
                end
                if (last_gnt_cyc >= 0) begin
                    checks++;
                    if (cyc - last_gnt_cyc < 2) begin
                        errors++;
                        $display("FAIL gnt_gap: got %0d cycles between grants, required >= 2", cyc - last_gnt_cyc);
                    end
                end
                last_gnt_cyc = cyc;
            end else if (MemRead || MemWrite) begin
                checks++;
                errors++;
                $display("FAIL strobe_no_gnt: got rd=%0b wr=%0b without grant, required 0", MemRead, MemWrite);
            end
            if (rvalid0 || rvalid1) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b, required none", rvalid0, rvalid1);
                end else begin
                    re = rq.pop_front();
                    if ((rvalid0 && rvalid1) || (rvalid1 != re.port) ||
                        ((rvalid1 ? rdata1 : rdata0) != re.data)) begin
                        errors++;
                        $display("FAIL rdata_check: got rvalid0=%0b rvalid1=%0b rdata0=%h rdata1=%h, required port=%0d data=%h",
                                 rvalid0, rvalid1, rdata0, rdata1, re.port, re.data);
                    end
                end
            end
        end else begin
            last_gnt_cyc = -1;
        end
    end

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endfunction

    // One request on a port: drive at posedge+1, wait for grant (bounded), then drop or keep
    task automatic access(input int p, input logic we, input logic [5:0] a,
                          input logic [31:0] d, input logic keep, output int gcyc);
        int n;
        logic got;
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if ((p == 0) ? gnt0 : gnt1) got = 1'b1;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: port %0d got no grant in 50 cycles, required grant", p);
        end
        gcyc = cyc;
        @(posedge clk);
        #1;
        if (!keep) begin
            if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        end
    endtask

    task automatic push_gnt(input logic p, input logic we, input logic [5:0] a, input logic [31:0] d);
        gq.push_back('{port: p, we: we, addr: a, wdata: d});
    endtask

    task automatic push_rd(input logic p, input logic [31:0] d);
        rq.push_back('{port: p, data: d});
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required finish");
        $fatal(1, "watchdog");
    end

    int g0, g1;
    int ga0 [3];
    int ga1 [3];
    int gb  [4];
    logic quiet_ok;

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        #1;
        check("reset_ctrl", {26'd0, gnt0, gnt1, rvalid0, rvalid1, MemRead, MemWrite, busy}, 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_rdata1", rdata1, 32'd0);
        check("reset_memaddr", {26'd0, MemAddr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention after reset: port 0 first, port 1 two cycles later
        push_gnt(1'b0, 1'b0, 6'd9, 32'd0);
        push_rd (1'b0, 32'hD000_0009);
        push_gnt(1'b1, 1'b0, 6'd10, 32'd0);
        push_rd (1'b1, 32'hD000_000A);
        fork
            access(0, 1'b0, 6'd9,  32'd0, 1'b0, g0);
            access(1, 1'b0, 6'd10, 32'd0, 1'b0, g1);
        join
        check("contention_gap", g1 - g0, 32'd2);
        idle_cycles(3);

        // Both held high: grants alternate 0,1,0,1,0,1 every two cycles
        for (int i = 0; i < 3; i++) begin
            push_gnt(1'b0, 1'b0, 6'd7, 32'd0);
            push_rd (1'b0, 32'hD000_0007);
            push_gnt(1'b1, 1'b0, 6'd8, 32'd0);
            push_rd (1'b1, 32'hD000_0008);
        end
        fork
            begin
                for (int i = 0; i < 3; i++) access(0, 1'b0, 6'd7, 32'd0, (i < 2), ga0[i]);
            end
            begin
                for (int j = 0; j < 3; j++) access(1, 1'b0, 6'd8, 32'd0, (j < 2), ga1[j]);
            end
        join
        check("alt_0_to_1", ga1[0] - ga0[0], 32'd2);
        check("alt_0_period", ga0[2] - ga0[1], 32'd4);
        idle_cycles(3);

        // Single read of mem[2]
        push_gnt(1'b0, 1'b0, 6'd2, 32'd0);
        push_rd (1'b0, 32'h0000_00A5);
        access(0, 1'b0, 6'd2, 32'd0, 1'b0, g0);
        idle_cycles(2);
        check("read_rdata0_held", rdata0, 32'h0000_00A5);

        // Single write on port 1: no rvalid, rdata1 keeps its last read value
        push_gnt(1'b1, 1'b1, 6'd14, 32'h0000_006E);
        access(1, 1'b1, 6'd14, 32'h0000_006E, 1'b0, g1);
        idle_cycles(3);
        check("write_rdata1_unchanged", rdata1, 32'hD000_0008);
        push_gnt(1'b0, 1'b0, 6'd14, 32'd0);
        push_rd (1'b0, 32'h0000_006E);
        access(0, 1'b0, 6'd14, 32'd0, 1'b0, g0);
        idle_cycles(3);

        // Back-to-back reads of addresses 0..3 on port 0
        push_gnt(1'b0, 1'b0, 6'd0, 32'd0); push_rd(1'b0, 32'hD000_0000);
        push_gnt(1'b0, 1'b0, 6'd1, 32'd0); push_rd(1'b0, 32'hD000_0001);
        push_gnt(1'b0, 1'b0, 6'd2, 32'd0); push_rd(1'b0, 32'h0000_00A5);
        push_gnt(1'b0, 1'b0, 6'd3, 32'd0); push_rd(1'b0, 32'hD000_0003);
        for (int k = 0; k < 4; k++) access(0, 1'b0, 6'(k), 32'd0, (k < 3), gb[k]);
        for (int k = 1; k < 4; k++) check("b2b_period", gb[k] - gb[k-1], 32'd2);
        idle_cycles(3);

        // Address change during grant cycle must not reach MemAddr
        push_gnt(1'b0, 1'b0, 6'd20, 32'd0);
        push_rd (1'b0, 32'hD000_0014);
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd20;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!gnt0 && n < 50);
            if (!gnt0) begin
                checks++;
                errors++;
                $display("FAIL stab_timeout: got no gnt0, required gnt0");
            end
        end
        #2;
        addr0 = 6'd21;
        #1;
        check("stab_memaddr", {26'd0, MemAddr}, 32'd20);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        idle_cycles(3);

        // Reset during the ACCESS cycle of a write to address 5
        push_gnt(1'b0, 1'b1, 6'd5, 32'hFFFF_FFFF);
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 32'hFFFF_FFFF;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!gnt0 && n < 50);
            if (!gnt0) begin
                checks++;
                errors++;
                $display("FAIL rst_timeout: got no gnt0, required gnt0");
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {26'd0, gnt0, gnt1, rvalid0, rvalid1, MemRead, MemWrite, busy}, 32'd0);
        check("rst_mid_memwdata", MemWData, 32'd0);
        check("rst_mid_rdata0", rdata0, 32'd0);
        req0 = 1'b0; we0 = 1'b0; addr0 = 6'd0; wdata0 = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_mem5", mem_rd(6'd5), 32'h0000_0055);

        // Quiet period: no requests means no activity for 20 cycles
        quiet_ok = 1'b1;
        for (int q = 0; q < 20; q++) begin
            @(negedge clk);
            if (busy || MemRead || MemWrite) quiet_ok = 1'b0;
        end
        check("quiet_20", {31'd0, quiet_ok}, 32'd1);

        idle_cycles(2);
        check("queues_drained", gq.size() + rq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
